wb_text_blit: RTL and testbench
===============================

# wb_text_blit

Wishbone-controlled text-buffer engine that clears or scrolls the 80x30 character/attribute RAM used by the text-mode video path. It sits on the Wishbone bus at slave base 0x20-0x2F alongside the video control slave and owns the write-capable port of the character RAM; the video scanout reads through the other port. Firmware issues one command byte, and the block sequences every RAM read and write, flags completion and returns to idle.

## Interface
- COLS, 80, characters per row
- ROWS, 30, rows in the buffer; COLS*ROWS must be <= 4096
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- wb_adr_i  in  8  Wishbone address; only [3:0] decoded
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  read data, registered
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_ack_o  out  1  one-cycle acknowledge
- ram_addr  out  12  character RAM address (row*COLS+col)
- ram_we  out  1  RAM write enable
- ram_wdata  out  16  write data {attr[15:8], char[7:0]}
- ram_rdata  in  16  read data, valid 1 cycle after address (sync RAM)
- busy_o  out  1  engine not idle
- done_o  out  1  one-cycle pulse when a command completes

## Operation
- Registers, by wb_adr_i[3:0]:
  - 0x0 CMD: write 0x01 = CLEAR, 0x02 = SCROLL; other values are ignored. Reads return 0x00.
  - 0x1 FILL_CHAR: R/W, reset value 0x20.
  - 0x2 FILL_ATTR: R/W, reset value 0x07.
  - 0x3 STATUS: read-only. bit0 = busy. bit1 = done, sticky. bit2 = err, sticky. A read returns the current value, then clears bits 1-2. If done or err is set in the same cycle as the read, the set wins.
  - 0x4 VERSION: reads 0x01.
  - All other addresses read 0x00 and ignore writes.
- Wishbone access:
  - When wb_cyc_i & wb_stb_i & !wb_ack_o, wb_ack_o asserts on the next clock for exactly one cycle, and any write takes effect on that edge.
  - A held strobe is acknowledged every other cycle.
- Command acceptance:
  - A CMD write is accepted only if state == IDLE on the ack edge.
  - A valid CMD written while busy is dropped and sets err.
- FSM states:
  - IDLE: no RAM activity, ram_we=0.
  - CLR: sequences the address ptr from 0 to N-1, where N = COLS*ROWS. Each cycle writes {FILL_ATTR, FILL_CHAR} at ptr. After ptr = N-1, go to FIN.
  - SRD: drives ram_addr = ptr+COLS with ram_we=0, then goes to SWR.
  - SWR: drives ram_addr = ptr, ram_wdata = ram_rdata, ram_we=1. Increments ptr. If ptr was N-COLS-1, go to FILL; otherwise go to SRD.
  - FILL: writes the fill word at ptr from N-COLS to N-1, then goes to FIN.
  - FIN: done_o=1, sets done, then goes to IDLE.
- Fill values are sampled at command acceptance. Writing FILL_* mid-command does not affect the running command.
- ptr is 12 bits. No arithmetic may wrap: the maximum address is N-1.

## Timing
- Reset values:
  - wb_ack_o=0, wb_dat_o=0x00
  - ram_addr=0, ram_we=0, ram_wdata=0
  - busy_o=0, done_o=0
  - state=IDLE, ptr=0, status bits=0
- Reset mid-command aborts immediately. RAM contents are left partially updated; no recovery is attempted.
- Start latency: the first ram_we or read address appears in the cycle after the CMD ack edge, and busy_o rises on that same edge.
- CLEAR takes N write cycles plus 1 FIN cycle: 2401 cycles from acceptance to done_o at default parameters.
- SCROLL takes 2*(N-COLS) + COLS + 1 cycles: 4721 at default parameters.
- busy_o is high in every non-IDLE state, including FIN, and is low the cycle after done_o.
- A CMD write in the FIN cycle is rejected with err.
- ram_addr, ram_we and ram_wdata are registered outputs.

## Test plan
- **Reset defaults:** assert rst and read 0x1/0x2/0x3/0x4 -> 0x20, 0x07, 0x00, 0x01. ram_we is never high.
- **CLEAR:** write FILL_CHAR=0x41, FILL_ATTR=0x1E, then CMD=0x01 -> 2400 consecutive writes of 0x1E41 at addresses 0..2399. done_o pulses 2401 cycles after acceptance. STATUS reads 0x02, then 0x00.
- **SCROLL:** preload the RAM model with cell[i]=i and issue CMD=0x02. Required result:
  - cell[i]=i+80 for i<2320.
  - cells 2320..2399 hold the fill word.
  - done_o pulses at cycle 4721.
- **Busy rejection:** write CMD=0x01 during a SCROLL -> the scroll completes unaltered and STATUS reads 0x07 mid-run. After completion and a clearing read, STATUS reads 0x00.
- **Invalid command:** write CMD=0x05 -> no RAM activity, busy stays 0 and err is not set.
- **Mid-command reset:** assert rst at cycle 100 of a CLEAR -> ram_we drops immediately. The next CLEAR runs a full 2400 writes starting at address 0.

Source files
------------

// File: rtl/wb_text_blit.sv
// wb_text_blit: Wishbone-driven clear/scroll engine for the 80x30 text character RAM.
module wb_text_blit #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    output logic [7:0]  wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        busy_o,
    output logic        done_o
);
    localparam logic [11:0] LAST  = 12'(COLS * ROWS - 1);
    localparam logic [11:0] SLAST = 12'(COLS * ROWS - COLS - 1);
    localparam logic [11:0] CO    = 12'(COLS);

    typedef enum logic [2:0] {IDLE, CLR, SRD, SWR, FILL, FIN} state_t;
    state_t      state, state_n;
    logic [11:0] ptr, ptr_n, addr_n;
    logic [15:0] fill_q, wdata_r, wdata_n;
    logic [7:0]  fill_char, fill_attr, rd_mux;
    logic [3:0]  a;
    logic        req, wr, rd_st, cmd_ok, accept, we_n, wd_sel, st_done, st_err;
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[7:4];
    assign a      = wb_adr_i[3:0];
    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr     = req & wb_we_i;
    assign rd_st  = req & ~wb_we_i & (a == 4'h3);
    assign cmd_ok = wr && a == 4'h0 && (wb_dat_i == 8'h01 || wb_dat_i == 8'h02);
    assign accept = cmd_ok && state == IDLE;
    assign busy_o = state != IDLE;
    assign done_o = state == FIN;
    // scroll writes forward the sync-RAM read data in the same cycle it arrives
    assign ram_wdata = wd_sel ? ram_rdata : wdata_r;
    assign rd_mux = a == 4'h1 ? fill_char :
                    a == 4'h2 ? fill_attr :
                    a == 4'h3 ? {5'b0, st_err, st_done, busy_o} :
                    a == 4'h4 ? 8'h01 : 8'h00;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        case (state)
            IDLE: if (accept) begin
                state_n = wb_dat_i[0] ? CLR : SRD;
                ptr_n   = '0;
            end
            CLR, FILL: if (ptr == LAST) state_n = FIN; else ptr_n = ptr + 12'd1;
            SRD: state_n = SWR;
            SWR: begin
                state_n = ptr == SLAST ? FILL : SRD;
                ptr_n   = ptr + 12'd1;
            end
            FIN: begin
                state_n = IDLE;
                ptr_n   = '0;
            end
            default: state_n = IDLE;
        endcase
        // RAM outputs are registered, so they are derived from the next state
        we_n    = state_n == CLR || state_n == SWR || state_n == FILL;
        addr_n  = state_n == SRD ? ptr_n + CO : (we_n ? ptr_n : '0);
        wdata_n = (state_n == CLR || state_n == FILL) ? (accept ? {fill_attr, fill_char} : fill_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            wdata_r   <= '0;
            wd_sel    <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            fill_char <= 8'h20;
            fill_attr <= 8'h07;
            fill_q    <= '0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            ram_addr <= addr_n;
            ram_we   <= we_n;
            wdata_r  <= wdata_n;
            wd_sel   <= state_n == SWR;
            wb_ack_o <= req;
            if (req & ~wb_we_i) wb_dat_o <= rd_mux;
            if (wr && a == 4'h1) fill_char <= wb_dat_i;
            if (wr && a == 4'h2) fill_attr <= wb_dat_i;
            if (accept) fill_q <= {fill_attr, fill_char};
            st_done <= (state == FIN) | (st_done & ~rd_st);
            st_err  <= (cmd_ok & ~accept) | (st_err & ~rd_st);
        end
    end
endmodule

// File: tb/tb_wb_text_blit.sv
// tb_wb_text_blit: scoreboard bench for wb_text_blit with a sync RAM model.
module tb_wb_text_blit;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic [11:0] ram_addr;
    logic        ram_we, busy_o, done_o;
    logic [15:0] ram_wdata, ram_rdata;
    logic [15:0] mem [0:4095];
    logic        preload = 1'b0, ack_rd = 1'b0;
    int          total = 0, bad = 0, cyc_cnt = 0, c0;
    logic [7:0]  rd_q[$];
    logic [27:0] wr_q[$];

    always #5 clk = ~clk;

    wb_text_blit dut (
        .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy_o(busy_o), .done_o(done_o)
    );

    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        ack_rd  <= wb_cyc_i & wb_stb_i & ~wb_we_i & ~wb_ack_o;
    end

    // monitor: pops the expected read data and RAM writes as the DUT presents them
    always @(negedge clk) begin
        if (wb_ack_o && ack_rd) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected got=%h", wb_dat_o);
            end else begin
                if (wb_dat_o !== rd_q[0]) begin
                    bad++;
                    $display("FAIL rd_data got=%h exp=%h", wb_dat_o, rd_q[0]);
                end
                void'(rd_q.pop_front());
            end
        end
        if (ram_we) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                if (bad < 20) $display("FAIL wr_unexpected got addr=%0d data=%h", ram_addr, ram_wdata);
            end else begin
                if ({ram_addr, ram_wdata} !== wr_q[0]) begin
                    bad++;
                    if (bad < 20) $display("FAIL wr_cell got addr=%0d data=%h exp addr=%0d data=%h",
                                           ram_addr, ram_wdata, wr_q[0][27:16], wr_q[0][15:0]);
                end
                void'(wr_q.pop_front());
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        while (wb_ack_o) @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = {4'h0, a}; wb_dat_i = d;
        do begin
            @(posedge clk); #1; n++;
        end while (!wb_ack_o && n < 8);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (!wb_ack_o) chk("ack_timeout", 0, 1);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus(1'b0, a, 8'h00);
    endtask

    task automatic wait_done(input int maxc, input string n, input int exp);
        for (int i = 0; i < maxc && !done_o; i++) @(negedge clk);
        chk(n, done_o ? cyc_cnt - c0 + 1 : -1, exp);
    endtask

    task automatic load_ram();
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
    endtask

    task automatic push_scroll(input logic [15:0] fw);
        for (int i = 0; i < 2400; i++) wr_q.push_back({12'(i), i < 2320 ? 16'(i + 80) : fw});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst = 1'b0;
        rd(4'h1, 8'h20); rd(4'h2, 8'h07); rd(4'h3, 8'h00); rd(4'h4, 8'h01); rd(4'h0, 8'h00); rd(4'h9, 8'h00);

        bus(1'b1, 4'h1, 8'h41);
        bus(1'b1, 4'h2, 8'h1E);
        for (int i = 0; i < 2400; i++) wr_q.push_back({12'(i), 16'h1E41});
        bus(1'b1, 4'h0, 8'h01);
        c0 = cyc_cnt;
        chk("clr_start_we", ram_we, 1);
        chk("clr_start_addr", ram_addr, 0);
        chk("clr_start_busy", busy_o, 1);
        bus(1'b1, 4'h1, 8'h55);
        wait_done(3000, "clr_latency", 2401);
        @(negedge clk);
        chk("clr_busy_after", busy_o, 0);
        rd(4'h3, 8'h02); rd(4'h3, 8'h00);
        chk("clr_wr_left", wr_q.size(), 0);

        load_ram();
        push_scroll(16'h1E55);
        bus(1'b1, 4'h0, 8'h02);
        c0 = cyc_cnt;
        chk("scr_start_we", ram_we, 0);
        chk("scr_start_addr", ram_addr, 80);
        wait_done(6000, "scr_latency", 4721);
        @(negedge clk);
        chk("scr_busy_after", busy_o, 0);
        chk("scr_cell0", mem[0], 16'd80);
        chk("scr_cell2319", mem[2319], 16'd2399);
        chk("scr_cell2399", mem[2399], 16'h1E55);
        chk("scr_wr_left", wr_q.size(), 0);

        load_ram();
        push_scroll(16'h1E55);
        bus(1'b1, 4'h0, 8'h02);
        c0 = cyc_cnt;
        bus(1'b1, 4'h0, 8'h01);
        rd(4'h3, 8'h07);
        wait_done(6000, "busy_latency", 4721);
        @(negedge clk);
        chk("busy_busy_after", busy_o, 0);
        rd(4'h3, 8'h02); rd(4'h3, 8'h00);
        chk("busy_wr_left", wr_q.size(), 0);

        bus(1'b1, 4'h0, 8'h05);
        repeat (4) @(negedge clk);
        chk("inv_busy", busy_o, 0);
        rd(4'h3, 8'h00);

        bus(1'b1, 4'h1, 8'h33);
        bus(1'b1, 4'h2, 8'h44);
        for (int i = 0; i < 99; i++) wr_q.push_back({12'(i), 16'h4433});
        bus(1'b1, 4'h0, 8'h01);
        repeat (99) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_we", ram_we, 0);
        chk("mrst_busy", busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_wr_left", wr_q.size(), 0);
        rd(4'h1, 8'h20); rd(4'h2, 8'h07);

        for (int i = 0; i < 2400; i++) wr_q.push_back({12'(i), 16'h0720});
        bus(1'b1, 4'h0, 8'h01);
        c0 = cyc_cnt;
        wait_done(3000, "clr2_latency", 2401);
        bus(1'b1, 4'h0, 8'h01);
        chk("fin_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        rd(4'h3, 8'h06); rd(4'h3, 8'h00);
        chk("clr2_wr_left", wr_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("rd_left", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
